mmio_access_sequencer: RTL and testbench
========================================

// Module: mmio_access_sequencer
// PURPOSE
//  Multi-cycle sequencer for load/store accesses that decode to the I/O window (addr[31:16]==16'hFFFF).
//  Takes the ioRead/ioWrite strobes from the decode stage and stalls the single-cycle core until the device completes.
//  Drives one selected peripheral (switches, LEDs, 7-seg, UART, ...) through a ready handshake.
//  Returns read data, or a bus error on timeout or on an unmapped device.
// PARAMETERS
//  NUM_DEV   4   number of peripheral slots; each slot is 16 bytes
//  DEV_LSB   4   lsb of the device index field in addr: idx = addr[DEV_LSB+3:DEV_LSB]
//  TIMEOUT   15  max cycles waiting for dev_ready before a bus error; range 1..255
// PORTS
//  clk           in   1             core clock
//  rst_n         in   1             synchronous, active-low reset
//  io_read       in   1             load to the I/O window; held stable while stall=1
//  io_write      in   1             store to the I/O window; held stable while stall=1
//  addr          in   32            effective address; held stable while stall=1
//  wdata         in   32            store data; held stable while stall=1
//  stall         out  1             freeze PC and register writeback
//  rdata         out  32            load result; valid in the cycle after stall falls
//  dev_sel       out  NUM_DEV       one-hot device select
//  dev_re        out  1             read strobe to the selected device
//  dev_we        out  1             write strobe to the selected device
//  dev_addr      out  4             addr[3:0], register offset inside the slot
//  dev_wdata     out  32            registered copy of wdata
//  dev_rdata     in   32*NUM_DEV    per-device read data; slot k is at [32k+31:32k]
//  dev_ready     in   NUM_DEV       per-device completion, 1-cycle pulse or level
//  bus_err       out  1             1-cycle pulse on an errored access
//  err_sticky    out  1             set by bus_err, cleared by err_clr
//  err_addr      out  32            addr of the most recent errored access
//  err_clr       in   1             clears err_sticky
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge)
//   - state=IDLE; all outputs 0; counter=0; err_sticky=0; err_addr=0.
//   - A reset during ACCESS abandons the transfer. Strobes drop on the next edge.
//  Request: req = io_read | io_write. If both are high, the access is a write.
//  stall is combinational: (state==IDLE & req) | state==ACCESS | state==ERR_WAIT.
//   - It therefore rises in the same cycle the request appears.
//  States
//   - IDLE: on req, latch addr, wdata and the direction.
//     - idx < NUM_DEV: go to ACCESS. dev_sel[idx], dev_re/dev_we and dev_addr are registered.
//     - idx >= NUM_DEV: go to ERR_WAIT. No strobe is issued.
//   - ACCESS: strobes and dev_sel are held; the counter increments each cycle.
//     - dev_ready[idx]=1: capture dev_rdata slot idx into rdata (reads only; writes leave rdata unchanged). Drop strobes, go to DONE.
//     - Otherwise, counter==TIMEOUT-1: drop strobes, go to ERR_WAIT.
//     - dev_ready of a non-selected device is ignored.
//   - ERR_WAIT (1 cycle): rdata=32'h0 for reads, bus_err=1, err_sticky=1, err_addr=latched addr. Go to DONE.
//   - DONE (1 cycle): stall=0, so the core retires the instruction at this edge. req is ignored here. Go to IDLE.
//     - A back-to-back I/O access therefore starts from IDLE in the following cycle.
//  Latency
//   - Device ready in cycle k of ACCESS (k=1..TIMEOUT): stall is high for k+1 cycles.
//   - Timeout: stall is high for TIMEOUT+2 cycles.
//   - Unmapped device: stall is high for 2 cycles.
//  Counter is 8 bits, cleared on entry to ACCESS, and never wraps (TIMEOUT<=255).
//  err_clr and a new error in the same cycle: the set wins.
//  No outputs other than stall are combinational from the inputs.
// TESTING
//  1. Write, idx 1, addr FFFF_FC14, wdata 0000_00A5; dev1 ready on the 1st ACCESS cycle.
//     -> dev_sel=0010, dev_we=1 for 1 cycle, dev_addr=4, dev_wdata=A5, stall high 2 cycles.
//  2. Read dev0 with ready on the 3rd ACCESS cycle, dev_rdata slot0=1234_5678.
//     -> stall high 4 cycles; rdata=1234_5678 in DONE.
//  3. Read dev2, dev_ready never asserted, TIMEOUT=15.
//     -> stall high 17 cycles; bus_err pulses once; rdata=0; err_sticky=1; err_addr=addr.
//  4. Read addr FFFF_FC70 (idx 7 >= NUM_DEV).
//     -> no dev_sel/strobe; bus_err pulses; stall high 2 cycles. Then err_clr -> err_sticky=0.
//  5. rst_n low for 1 cycle in the 2nd ACCESS cycle.
//     -> the next cycle shows IDLE: dev_sel=0, strobes=0, err_sticky=0, and stall tracks req only.
//  6. Back-to-back writes to dev3 then dev0, each ready immediately.
//     -> two separate 2-cycle stalls with one unstalled DONE cycle between; dev_ready from dev0 during the first access is ignored.

Source files
------------

// File: rtl/mmio_access_sequencer.sv
// Multi-cycle sequencer for I/O-window loads/stores: stalls the core, drives one
// peripheral slot through a ready handshake, and reports timeouts/unmapped slots.
//   S_IDLE     | waiting for a request
//   S_ACCESS   | strobes held, waiting for the device's ready
//   S_ERR_WAIT | one-cycle bus error report
//   S_DONE     | stall released; the core retires the access
module mmio_access_sequencer #(
    parameter int NUM_DEV = 4,
    parameter int DEV_LSB = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    io_read_i,
    input  logic                    io_write_i,
    input  logic [31:0]             addr_i,
    input  logic [31:0]             wdata_i,
    output logic                    stall_o,
    output logic [31:0]             rdata_o,
    output logic [NUM_DEV-1:0]      dev_sel_o,
    output logic                    dev_re_o,
    output logic                    dev_we_o,
    output logic [3:0]              dev_addr_o,
    output logic [31:0]             dev_wdata_o,
    input  logic [32*NUM_DEV-1:0]   dev_rdata_i,
    input  logic [NUM_DEV-1:0]      dev_ready_i,
    output logic                    bus_err_o,
    output logic                    err_sticky_o,
    output logic [31:0]             err_addr_o,
    input  logic                    err_clr_i
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACCESS   = 2'd1,
        S_ERR_WAIT = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [31:0]          addr_q, addr_d;
    logic                 is_wr_q, is_wr_d;
    logic [NUM_DEV-1:0]   sel_q, sel_d;
    logic                 re_q, re_d;
    logic                 we_q, we_d;
    logic [3:0]           dev_addr_q, dev_addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 bus_err_q, bus_err_d;
    logic                 sticky_q, sticky_d;
    logic [31:0]          err_addr_q, err_addr_d;

    logic                 req;
    logic [3:0]           idx;
    logic [31:0]          idx_ext;
    logic                 mapped;
    logic [NUM_DEV-1:0]   sel_new;
    logic                 ready_hit;
    logic [31:0]          sel_rdata;

    assign req     = io_read_i | io_write_i;
    assign idx     = addr_i[DEV_LSB+3:DEV_LSB];
    assign idx_ext = {28'd0, idx};
    assign mapped  = idx_ext < 32'(NUM_DEV);

    always_comb begin
        sel_new = '0;
        for (int k = 0; k < NUM_DEV; k++) begin
            sel_new[k] = (idx_ext == 32'(k));
        end
    end

    // Only the selected slot's ready counts; others are masked by the held select.
    assign ready_hit = |(dev_ready_i & sel_q);

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < NUM_DEV; k++) begin
            if (sel_q[k]) begin
                sel_rdata = sel_rdata | dev_rdata_i[32*k +: 32];
            end
        end
    end

    assign stall_o = ((state_q == S_IDLE) && req) ||
                     (state_q == S_ACCESS) ||
                     (state_q == S_ERR_WAIT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        is_wr_d    = is_wr_q;
        sel_d      = sel_q;
        re_d       = re_q;
        we_d       = we_q;
        dev_addr_d = dev_addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        bus_err_d  = 1'b0;
        err_addr_d = err_addr_q;
        // A clear is overridden below when an error is entered on the same edge.
        sticky_d   = sticky_q & ~err_clr_i;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d     = addr_i;
                    is_wr_d    = io_write_i;
                    wdata_d    = wdata_i;
                    dev_addr_d = addr_i[3:0];
                    if (mapped) begin
                        sel_d   = sel_new;
                        we_d    = io_write_i;
                        re_d    = ~io_write_i;
                        cnt_d   = 8'd0;
                        state_d = S_ACCESS;
                    end else begin
                        bus_err_d  = 1'b1;
                        sticky_d   = 1'b1;
                        err_addr_d = addr_i;
                        if (!io_write_i) begin
                            rdata_d = 32'h0;
                        end
                        state_d = S_ERR_WAIT;
                    end
                end
            end
            S_ACCESS: begin
                if (ready_hit) begin
                    if (!is_wr_q) begin
                        rdata_d = sel_rdata;
                    end
                    sel_d   = '0;
                    re_d    = 1'b0;
                    we_d    = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    sel_d      = '0;
                    re_d       = 1'b0;
                    we_d       = 1'b0;
                    bus_err_d  = 1'b1;
                    sticky_d   = 1'b1;
                    err_addr_d = addr_q;
                    if (!is_wr_q) begin
                        rdata_d = 32'h0;
                    end
                    state_d = S_ERR_WAIT;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ERR_WAIT: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            addr_q     <= 32'h0;
            is_wr_q    <= 1'b0;
            sel_q      <= '0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            dev_addr_q <= 4'h0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            bus_err_q  <= 1'b0;
            sticky_q   <= 1'b0;
            err_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            is_wr_q    <= is_wr_d;
            sel_q      <= sel_d;
            re_q       <= re_d;
            we_q       <= we_d;
            dev_addr_q <= dev_addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            bus_err_q  <= bus_err_d;
            sticky_q   <= sticky_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign rdata_o      = rdata_q;
    assign dev_sel_o    = sel_q;
    assign dev_re_o     = re_q;
    assign dev_we_o     = we_q;
    assign dev_addr_o   = dev_addr_q;
    assign dev_wdata_o  = wdata_q;
    assign bus_err_o    = bus_err_q;
    assign err_sticky_o = sticky_q;
    assign err_addr_o   = err_addr_q;

endmodule

// File: tb/tb_mmio_access_sequencer.sv
// Bench for mmio_access_sequencer: directed scenarios plus randomized accesses
// checked against a transaction-level expectation of stall length, strobes and errors.
module tb_mmio_access_sequencer;

    localparam int NUM_DEV = 4;
    localparam int T       = 15;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  io_read, io_write, err_clr;
    logic [31:0]           addr, wdata;
    logic [32*NUM_DEV-1:0] dev_rdata;
    logic [NUM_DEV-1:0]    dev_ready;
    logic                  stall, dev_re, dev_we, bus_err, err_sticky;
    logic [31:0]           rdata, dev_wdata, err_addr;
    logic [NUM_DEV-1:0]    dev_sel;
    logic [3:0]            dev_addr;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_rdata    = 32'h0;
    logic [31:0] m_err_addr = 32'h0;
    logic        m_sticky   = 1'b0;

    always #5 clk = ~clk;

    mmio_access_sequencer #(.NUM_DEV(NUM_DEV), .DEV_LSB(4), .TIMEOUT(T)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .io_read_i    (io_read),
        .io_write_i   (io_write),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .stall_o      (stall),
        .rdata_o      (rdata),
        .dev_sel_o    (dev_sel),
        .dev_re_o     (dev_re),
        .dev_we_o     (dev_we),
        .dev_addr_o   (dev_addr),
        .dev_wdata_o  (dev_wdata),
        .dev_rdata_i  (dev_rdata),
        .dev_ready_i  (dev_ready),
        .bus_err_o    (bus_err),
        .err_sticky_o (err_sticky),
        .err_addr_o   (err_addr),
        .err_clr_i    (err_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access. k = ACCESS cycle in which the device is ready (k>T: never).
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input int k, input bit lvl,
                             input logic [NUM_DEV-1:0] noise, input int clr_c,
                             input logic [31:0] rdval, input string tag);
        int                 idx;
        bit                 mapped, err, done, active;
        int                 e, exp_stall, last_act, n, bad_strb, bad_berr;
        logic [NUM_DEV-1:0] oh;
        logic               s;
        idx    = int'(a[7:4]);
        mapped = idx < NUM_DEV;
        oh     = '0;
        if (mapped) oh[idx] = 1'b1;
        if (!mapped) begin
            err = 1; e = 0; exp_stall = 2; last_act = 0;
        end else if (k <= T) begin
            err = 0; e = -10; exp_stall = k + 1; last_act = k;
        end else begin
            err = 1; e = T; exp_stall = T + 2; last_act = T;
        end
        s = m_sticky;
        for (int j = 0; j < exp_stall; j++) begin
            if (err && j == e) s = 1'b1;
            else if (j == clr_c) s = 1'b0;
        end

        @(posedge clk); #1;
        io_read  = rd;
        io_write = wr;
        addr     = a;
        wdata    = wd;
        for (int d = 0; d < NUM_DEV; d++) dev_rdata[32*d +: 32] = (d == idx) ? rdval : $urandom();
        n = 0; done = 0; bad_strb = 0; bad_berr = 0;
        while (!done && n <= 40) begin
            dev_ready = noise & ~oh;
            if (mapped && (n == k || (lvl && n >= k))) dev_ready = dev_ready | oh;
            err_clr = (n == clr_c);
            @(negedge clk);
            active = mapped && n >= 1 && n <= last_act;
            if (dev_sel !== (active ? oh : '0) || dev_we !== (active && wr) ||
                dev_re !== (active && rd && !wr)) bad_strb++;
            if (active && (dev_addr !== a[3:0] || dev_wdata !== wd)) bad_strb++;
            if (bus_err !== (err && n == e + 1)) bad_berr++;
            if (stall !== 1'b1) done = 1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        err_clr = 1'b0;

        if (rd && !wr) m_rdata = (mapped && !err) ? rdval : 32'h0;
        if (err) m_err_addr = a;
        m_sticky = s;

        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_stall_len"}, n, exp_stall);
        check_eq({tag, "_strobes"}, bad_strb, 0);
        check_eq({tag, "_bus_err"}, bad_berr, 0);
        check_eq({tag, "_rdata"}, rdata, m_rdata);
        check_eq({tag, "_sticky"}, 32'(err_sticky), 32'(m_sticky));
        check_eq({tag, "_err_addr"}, err_addr, m_err_addr);
        if (mapped) begin
            check_eq({tag, "_dev_addr"}, 32'(dev_addr), 32'(a[3:0]));
            check_eq({tag, "_dev_wdata"}, dev_wdata, wd);
        end
    endtask

    task automatic idle_cycle(input bit clr);
        @(posedge clk); #1;
        io_read   = 1'b0;
        io_write  = 1'b0;
        err_clr   = clr;
        dev_ready = NUM_DEV'($urandom());
        @(negedge clk);
        check_eq("idle_stall", 32'(stall), 32'd0);
        check_eq("idle_sticky", 32'(err_sticky), 32'(m_sticky));
        if (clr) m_sticky = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; io_read = 1'b0; io_write = 1'b0; err_clr = 1'b0;
        addr = 32'h0; wdata = 32'h0; dev_rdata = '0; dev_ready = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_sel", 32'(dev_sel), 32'd0);
        check_eq("rst_strobes", 32'({dev_re, dev_we, bus_err}), 32'd0);
        check_eq("rst_sticky", 32'(err_sticky), 32'd0);
        check_eq("rst_err_addr", err_addr, 32'h0);

        do_access(1'b0, 1'b1, 32'hFFFF_FC14, 32'h0000_00A5, 1, 1'b0, '0, -1, 32'h0, "t1_wr_dev1");
        do_access(1'b1, 1'b0, 32'hFFFF_FC00, 32'h0, 3, 1'b0, '0, -1, 32'h1234_5678, "t2_rd_dev0");
        do_access(1'b1, 1'b0, 32'hFFFF_FC20, 32'h0, T + 5, 1'b0, '0, -1, 32'hDEAD_BEEF, "t3_timeout");
        do_access(1'b1, 1'b0, 32'hFFFF_FC70, 32'h0, 1, 1'b0, '0, -1, 32'h5555_AAAA, "t4_unmapped");
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        do_access(1'b1, 1'b0, 32'hFFFF_FC50, 32'h0, 1, 1'b0, '0, 0, 32'h0, "set_wins");

        // Reset during the second ACCESS cycle of a never-ready read.
        @(posedge clk); #1;
        io_read = 1'b1; io_write = 1'b0; addr = 32'hFFFF_FC20; dev_ready = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("t5_pre_re", 32'({dev_re, dev_sel}), 32'({1'b1, 4'b0100}));
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1; io_read = 1'b0;
        @(negedge clk);
        m_rdata = 32'h0; m_sticky = 1'b0; m_err_addr = 32'h0;
        check_eq("t5_stall", 32'(stall), 32'd0);
        check_eq("t5_sel", 32'(dev_sel), 32'd0);
        check_eq("t5_strobes", 32'({dev_re, dev_we, bus_err}), 32'd0);
        check_eq("t5_sticky", 32'(err_sticky), 32'd0);
        check_eq("t5_err_addr", err_addr, 32'h0);

        do_access(1'b0, 1'b1, 32'hFFFF_FC38, 32'hCAFE_0003, 1, 1'b0, 4'b0001, -1, 32'h0, "t6_wr_dev3");
        do_access(1'b0, 1'b1, 32'hFFFF_FC0C, 32'hCAFE_0000, 1, 1'b0, '0, -1, 32'h0, "t6_wr_dev0");

        for (int t = 0; t < 200; t++) begin
            int                 dir, idx, k, clr_c;
            logic [31:0]        a;
            dir   = $urandom_range(1, 3);
            idx   = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
            a     = {16'hFFFF, 8'($urandom()), 4'(idx), 4'($urandom())};
            k     = $urandom_range(1, T + 3);
            clr_c = ($urandom_range(0, 2) == 0) ? $urandom_range(0, T + 2) : -1;
            do_access(dir[0], dir[1], a, $urandom(), k, 1'($urandom_range(0, 1)),
                      NUM_DEV'($urandom()), clr_c, $urandom(), "rnd");
            repeat ($urandom_range(0, 2)) idle_cycle($urandom_range(0, 4) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
